// File: rtl/cam_cap_pkg.sv
// rtl/cam_cap_pkg.sv - shared types and width helpers for the DVP capture block
//
// Contents:
//   state_t      capture FSM states
//   pix_entry_t  one output FIFO entry {sof, eol, y, x, data}; the coordinate
//                fields are sized for the largest supported frame and are
//                truncated to the configured width at the output
//   calc_xw/yw   coordinate port widths for a given active size
package cam_cap_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_DONE
  } state_t;

  localparam int XW_MAX = 12;
  localparam int YW_MAX = 12;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [YW_MAX-1:0] y;
    logic [XW_MAX-1:0] x;
    logic [15:0]       data;
  } pix_entry_t;

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_xw(input int h_active);
    return coord_w(h_active);
  endfunction

  function automatic int calc_yw(input int v_active);
    return coord_w(v_active);
  endfunction

endpackage

// File: rtl/cam_dvp_capture_if.sv
// rtl/cam_dvp_capture_if.sv - pixel output stream with valid/ready handshake
//
// Signals:
//   pix_valid  head entry valid           (master -> slave)
//   pix_ready  slave accepts head entry   (slave -> master)
//   pix_data   RGB565 pixel
//   pix_x/y    pixel coordinates
//   pix_sof    head is pixel (0,0)
//   pix_eol    head is the last pixel of its line
interface cam_dvp_capture_if
  import cam_cap_pkg::*;
#(
  parameter int XW = calc_xw(640),
  parameter int YW = calc_yw(480)
) ();

  logic          pix_valid;
  logic          pix_ready;
  logic [15:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_sof;
  logic          pix_eol;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    output pix_ready
  );

endinterface

// File: rtl/cam_pix_fifo.sv
// rtl/cam_pix_fifo.sv - first-word-fall-through FIFO for captured pixels
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   push, push_data  write request; accepted when not full or popping
//   pop            remove head (ignored when empty)
//   pop_data       current head entry (valid when !empty)
//   full, empty, count  occupancy status
module cam_pix_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/cam_dvp_capture.sv
// rtl/cam_dvp_capture.sv - DVP camera capture: byte pairing, coordinates, size checks
//
// Ports:
//   clk, reset_n          camera pixel clock, async active-low reset
//   cam_vs/cam_hs/cam_data  VSYNC, HREF and data byte from the sensor
//   capture_en            frame capture enable, looked at only at frame start
//   ovf_clr               clears the sticky overflow flag
//   pix                   pixel stream (master side of cam_dvp_capture_if)
//   overflow              sticky: a pixel was dropped on a full FIFO
//   size_err              one-cycle pulse at frame end for a malformed frame
//   frame_cnt             completed captured frames, wrapping
module cam_dvp_capture
  import cam_cap_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int BYTE_SWAP  = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cam_vs,
  input  logic       cam_hs,
  input  logic [7:0] cam_data,
  input  logic       capture_en,
  input  logic       ovf_clr,
  cam_dvp_capture_if.master pix,
  output logic       overflow,
  output logic       size_err,
  output logic [7:0] frame_cnt
);

  localparam int XW = calc_xw(H_ACTIVE);
  localparam int YW = calc_yw(V_ACTIVE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Counters carry one extra bit and saturate just past the active size, so
  // an over-long line or frame can never wrap back into the valid range.
  localparam logic [XW:0] X_END = (XW + 1)'(H_ACTIVE);
  localparam logic [YW:0] Y_END = (YW + 1)'(V_ACTIVE);

  logic vs_q, hs_q, vs_qq, hs_qq;
  logic [7:0] d_q;
  logic vs_fall, vs_rise, hs_fall;

  state_t      state, state_n;
  logic [XW:0] x_cnt, x_n;
  logic [YW:0] y_cnt, y_n;
  logic        phase, phase_n;
  logic        err, err_n;
  logic [7:0]  byte0, byte0_n;
  logic        size_err_n;
  logic [7:0]  frame_cnt_n;
  logic        push_req;

  pix_entry_t      wr_entry, head;
  logic            fifo_full, fifo_empty, fifo_pop, accept, drop;
  logic [CW-1:0]   fifo_count;

  assign vs_fall = vs_qq && !vs_q;
  assign vs_rise = !vs_qq && vs_q;
  assign hs_fall = hs_qq && !hs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q  <= 1'b0;
      hs_q  <= 1'b0;
      d_q   <= '0;
      vs_qq <= 1'b0;
      hs_qq <= 1'b0;
    end else begin
      vs_q  <= cam_vs;
      hs_q  <= cam_hs;
      d_q   <= cam_data;
      vs_qq <= vs_q;
      hs_qq <= hs_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    x_n         = x_cnt;
    y_n         = y_cnt;
    phase_n     = phase;
    err_n       = err;
    byte0_n     = byte0;
    size_err_n  = 1'b0;
    frame_cnt_n = frame_cnt;
    push_req    = 1'b0;
    case (state)
      S_IDLE: begin
        x_n     = '0;
        y_n     = '0;
        phase_n = 1'b0;
        err_n   = 1'b0;
        if (vs_fall && capture_en) state_n = S_FRAME;
      end
      S_FRAME: begin
        if (hs_q) begin
          if (!phase) begin
            byte0_n = d_q;
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            if (x_cnt < X_END && y_cnt < Y_END) push_req = 1'b1;
            else                                err_n    = 1'b1;
            if (x_cnt <= X_END) x_n = x_cnt + 1'b1;
          end
        end else if (hs_fall) begin
          if (phase || x_cnt != X_END) err_n = 1'b1;
          if (y_cnt <= Y_END) y_n = y_cnt + 1'b1;
          x_n     = '0;
          phase_n = 1'b0;
        end
        if (vs_rise) begin
          // A line that ends in this same cycle was already closed above.
          if (!hs_fall && (hs_q || phase || x_cnt != '0)) err_n = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        size_err_n  = err || (y_cnt != Y_END);
        frame_cnt_n = frame_cnt + 1'b1;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      phase     <= 1'b0;
      err       <= 1'b0;
      byte0     <= '0;
      size_err  <= 1'b0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      x_cnt     <= x_n;
      y_cnt     <= y_n;
      phase     <= phase_n;
      err       <= err_n;
      byte0     <= byte0_n;
      size_err  <= size_err_n;
      frame_cnt <= frame_cnt_n;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    wr_entry.sof  = (x_cnt == '0) && (y_cnt == '0);
    wr_entry.eol  = (x_cnt == X_END - 1'b1);
    wr_entry.y    = YW_MAX'(y_cnt);
    wr_entry.x    = XW_MAX'(x_cnt);
    wr_entry.data = (BYTE_SWAP != 0) ? {d_q, byte0} : {byte0, d_q};
  end

  assign fifo_pop = !fifo_empty && pix.pix_ready;
  assign accept   = (fifo_count < CW'(FIFO_DEPTH)) || fifo_pop;
  assign drop     = push_req && !accept;

  cam_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pix_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (wr_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  full_matches_count: assert property (@(posedge clk) disable iff (!reset_n)
    fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

  assign pix.pix_valid = !fifo_empty;
  assign pix.pix_data  = head.data;
  assign pix.pix_x     = XW'(head.x);
  assign pix.pix_y     = YW'(head.y);
  assign pix.pix_sof   = head.sof;
  assign pix.pix_eol   = head.eol;

endmodule

// File: tb/tb_cam_dvp_capture.sv
// tb/tb_cam_dvp_capture.sv - scoreboard bench for cam_dvp_capture
module tb_cam_dvp_capture;

  localparam int H = 4;
  localparam int V = 2;

  typedef logic [20:0] ent_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cam_vs = 1'b1;
  logic       cam_hs = 1'b0;
  logic [7:0] cam_data = '0;
  logic       capture_en = 1'b1;
  logic       capture_en_sw = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ready = 1'b1;
  logic       overflow, size_err, overflow_sw, size_err_sw;
  logic [7:0] frame_cnt, frame_cnt_sw;

  logic [15:0] tbl [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
                           16'h1234, 16'hABCD, 16'h0F0F, 16'h8001};

  ent_t       q[$];
  ent_t       q_sw[$];
  ent_t       act_m, exp_m, act_s, exp_s;
  int         n_vec = 0;
  int         n_bad = 0;
  int         pushed;
  int         max_push;
  bit         cap_m, cap_sw_m;
  logic [7:0] exp_fc = '0;

  always #5 clk = ~clk;

  cam_dvp_capture_if #(.XW(2), .YW(1)) pif ();
  cam_dvp_capture_if #(.XW(2), .YW(1)) pif_sw ();

  assign pif.pix_ready    = ready;
  assign pif_sw.pix_ready = 1'b1;

  cam_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(4), .BYTE_SWAP(0)) dut (
    .clk(clk), .reset_n(reset_n), .cam_vs(cam_vs), .cam_hs(cam_hs), .cam_data(cam_data),
    .capture_en(capture_en), .ovf_clr(ovf_clr), .pix(pif),
    .overflow(overflow), .size_err(size_err), .frame_cnt(frame_cnt)
  );

  cam_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(4), .BYTE_SWAP(1)) dut_sw (
    .clk(clk), .reset_n(reset_n), .cam_vs(cam_vs), .cam_hs(cam_hs), .cam_data(cam_data),
    .capture_en(capture_en_sw), .ovf_clr(ovf_clr), .pix(pif_sw),
    .overflow(overflow_sw), .size_err(size_err_sw), .frame_cnt(frame_cnt_sw)
  );

  function automatic ent_t mk(input logic [15:0] d, input int x, input int y);
    return {(x == 0 && y == 0), (x == H - 1), 1'(y), 2'(x), d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && pif.pix_valid && pif.pix_ready) begin
      act_m = {pif.pix_sof, pif.pix_eol, pif.pix_y, pif.pix_x, pif.pix_data};
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL pixel: unexpected entry %h at %0t", act_m, $time);
      end else begin
        exp_m = q.pop_front();
        check("pixel", 32'(act_m), 32'(exp_m));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && pif_sw.pix_valid) begin
      act_s = {pif_sw.pix_sof, pif_sw.pix_eol, pif_sw.pix_y, pif_sw.pix_x, pif_sw.pix_data};
      if (q_sw.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL swap_pixel: unexpected entry %h at %0t", act_s, $time);
      end else begin
        exp_s = q_sw.pop_front();
        check("swap_pixel", 32'(act_s), 32'(exp_s));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cam_hs   = 1'b0;
      cam_data = '0;
    end
  endtask

  task automatic frame_start(input logic en, input logic en_sw);
    @(posedge clk); #1;
    capture_en    = en;
    capture_en_sw = en_sw;
    cam_vs        = 1'b0;
    idle(3);
  endtask

  task automatic send_line(input int fid, input int l, input int first, input int last,
                           input bit lat);
    int x;
    logic [15:0] d;
    for (int i = first; i <= last; i++) begin
      x = i / 2;
      d = tbl[(l * H + x + fid) % 8];
      @(posedge clk); #1;
      if (lat && l == 0 && i == 2) check("latency_before", 32'(pif.pix_valid), 32'd0);
      if (lat && l == 0 && i == 3) check("latency_after", 32'(pif.pix_valid), 32'd1);
      cam_hs   = 1'b1;
      cam_data = (i % 2 == 0) ? d[15:8] : d[7:0];
      if (i % 2 == 1) begin
        if (cap_m && pushed < max_push) begin
          q.push_back(mk(d, x, l));
          pushed++;
        end
        if (cap_sw_m) q_sw.push_back(mk({d[7:0], d[15:8]}, x, l));
      end
    end
  endtask

  task automatic frame_end(input logic exp_serr);
    @(posedge clk); #1;
    cam_vs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("size_err_early", 32'(size_err), 32'd0);
    @(negedge clk);
    check("size_err", 32'(size_err), 32'(exp_serr));
    @(negedge clk);
    check("size_err_width", 32'(size_err), 32'd0);
    idle(2);
  endtask

  task automatic send_frame(input int fid, input int len0, input int len1, input bit cap,
                            input bit cap_sw, input int mp, input logic exp_serr, input bit lat);
    cap_m    = cap;
    cap_sw_m = cap_sw;
    max_push = mp;
    pushed   = 0;
    frame_start(cap, cap_sw);
    send_line(fid, 0, 0, len0 - 1, lat);
    idle(3);
    send_line(fid, 1, 0, len1 - 1, 1'b0);
    idle(3);
    frame_end(exp_serr);
    if (cap) exp_fc = exp_fc + 8'd1;
    check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && q_sw.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    check("drain_main", 32'(q.size()), 32'd0);
    check("drain_swap", 32'(q_sw.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_valid", 32'(pif.pix_valid), 32'd0);
    check("rst_data", 32'(pif.pix_data), 32'd0);
    check("rst_x", 32'(pif.pix_x), 32'd0);
    check("rst_y", 32'(pif.pix_y), 32'd0);
    check("rst_sof", 32'(pif.pix_sof), 32'd0);
    check("rst_eol", 32'(pif.pix_eol), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_size_err", 32'(size_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset_n = 1'b1;
    idle(2);

    // Nominal frame, including first-pixel latency.
    send_frame(0, 8, 8, 1'b1, 1'b0, 100, 1'b0, 1'b1);
    drain();
    check("nominal_overflow", 32'(overflow), 32'd0);

    // Short second line: 7 bytes -> 3 pixels, frame flagged.
    send_frame(1, 8, 7, 1'b1, 1'b0, 100, 1'b1, 1'b0);
    drain();

    // Backpressure over a whole frame: only the first 4 pixels survive.
    ready = 1'b0;
    send_frame(2, 8, 8, 1'b1, 1'b0, 4, 1'b0, 1'b0);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_valid", 32'(pif.pix_valid), 32'd1);
    check("bp_head_data", 32'(pif.pix_data), 32'h001F);
    check("bp_head_x", 32'(pif.pix_x), 32'd0);
    @(posedge clk); #1;
    check("bp_head_stable", 32'(pif.pix_data), 32'h001F);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    ready = 1'b1;
    drain();
    check("bp_empty_after_drain", 32'(pif.pix_valid), 32'd0);

    // Skipped frame: enable low at frame start, raised mid-frame.
    cap_m    = 1'b0;
    cap_sw_m = 1'b0;
    pushed   = 0;
    frame_start(1'b0, 1'b0);
    capture_en = 1'b1;
    send_line(3, 0, 0, 7, 1'b0);
    idle(3);
    send_line(3, 1, 0, 7, 1'b0);
    idle(3);
    frame_end(1'b0);
    check("skip_frame_cnt", 32'(frame_cnt), 32'(exp_fc));

    // Following frame is captured normally.
    send_frame(6, 8, 8, 1'b1, 1'b0, 100, 1'b0, 1'b0);
    drain();

    // Reset in the middle of line 0, after 3 pixels.
    cap_m    = 1'b1;
    cap_sw_m = 1'b0;
    max_push = 100;
    pushed   = 0;
    frame_start(1'b1, 1'b0);
    send_line(5, 0, 0, 6, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    exp_fc = '0;
    cap_m  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_line(5, 0, 7, 7, 1'b0);
    idle(3);
    send_line(5, 1, 0, 7, 1'b0);
    idle(3);
    frame_end(1'b0);
    check("rst_frame_ignored", 32'(frame_cnt), 32'd0);
    drain();

    send_frame(7, 8, 8, 1'b1, 1'b0, 100, 1'b0, 1'b0);
    drain();

    // Byte order: first pixel bytes 0x12,0x34 on both instances.
    send_frame(4, 8, 8, 1'b1, 1'b1, 100, 1'b0, 1'b0);
    drain();
    check("swap_frame_cnt", 32'(frame_cnt_sw), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
